// File: rtl/mem_pkg.sv
// Shared memory-stage definitions: access-size codes, LWL/LWR merge codes and
// the formatted load beat carried from the lane extractor to the output stage.
package mem_pkg;

  localparam int MEM_NB_MAX = 64;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_DWORD = 2'b10;
  localparam logic [1:0] SZ_WORD  = 2'b11;

  localparam logic [1:0] MRG_NONE = 2'b00;
  localparam logic [1:0] MRG_LWL  = 2'b01;
  localparam logic [1:0] MRG_LWR  = 2'b10;

  // dato is sized for the widest datapath; narrower builds zero the upper bits.
  typedef struct packed {
    logic [MEM_NB_MAX-1:0] dato;
    logic                  misaligned;
  } load_beat_t;

endpackage

// File: rtl/load_lane_extract.sv
// Combinational byte-lane select, zero/sign extension and misalignment check.
// With LOAD_UNALIGNED_EN defined, word accesses also support LWL/LWR merging.
module load_lane_extract
  import mem_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_MASK = 2,
  parameter int NB_OFS  = $clog2(NB_DATA/8)
) (
  input  logic [NB_DATA-1:0] dato,
  input  logic [NB_OFS-1:0]  offset,
  input  logic [NB_MASK-1:0] mascara,
  input  logic               is_unsigned,
  input  logic [1:0]         merge_mode,
  input  logic [NB_DATA-1:0] rt_old,
  output load_beat_t         beat
);

  logic [7:0]         byte_f;
  logic [15:0]        half_f;
  logic [31:0]        word_f;
  logic [NB_DATA-1:0] res;
  logic               mis;
  logic               sx;

`ifdef LOAD_UNALIGNED_EN
  logic [31:0] mrg;
  int          k;
`else
  logic unused_merge;
  assign unused_merge = ^{merge_mode, rt_old};
`endif

  always_comb begin
    byte_f = dato[8*offset +: 8];
    half_f = dato[16*offset[NB_OFS-1:1] +: 16];
    word_f = dato[32*(int'(offset) >> 2) +: 32];
    sx     = !is_unsigned;
    res    = '0;
    mis    = 1'b0;

    case (mascara)
      SZ_BYTE: begin
        res      = {NB_DATA{sx & byte_f[7]}};
        res[7:0] = byte_f;
      end
      SZ_HALF: begin
        if (offset[0]) begin
          mis = 1'b1;
        end else begin
          res       = {NB_DATA{sx & half_f[15]}};
          res[15:0] = half_f;
        end
      end
      SZ_DWORD: begin
        // A 32-bit datapath has no dword, so code 10 degrades to a word load.
        if (NB_DATA == 64) begin
          if (offset != '0) mis = 1'b1;
          else              res = dato;
        end else begin
          if (offset[1:0] != 2'b00) begin
            mis = 1'b1;
          end else begin
            res       = {NB_DATA{sx & word_f[31]}};
            res[31:0] = word_f;
          end
        end
      end
      default: begin
        if (offset[1:0] != 2'b00) begin
          mis = 1'b1;
        end else begin
          res       = {NB_DATA{sx & word_f[31]}};
          res[31:0] = word_f;
        end
      end
    endcase

`ifdef LOAD_UNALIGNED_EN
    k   = int'(offset[1:0]);
    mrg = '0;
    if (mascara == SZ_WORD && merge_mode == MRG_LWL) begin
      mrg = (word_f << (8*(3-k))) | (rt_old[31:0] & (32'hFFFF_FFFF >> (8*(k+1))));
    end else if (mascara == SZ_WORD && merge_mode == MRG_LWR) begin
      mrg = (word_f >> (8*k)) | (rt_old[31:0] & ~(32'hFFFF_FFFF >> (8*k)));
    end
    // Merges are unaligned by design, so they never raise the address-error flag.
    if (mascara == SZ_WORD && (merge_mode == MRG_LWL || merge_mode == MRG_LWR)) begin
      mis       = 1'b0;
      res       = {NB_DATA{mrg[31]}};
      res[31:0] = mrg;
    end
`endif

    beat                    = '0;
    beat.dato[NB_DATA-1:0]  = mis ? '0 : res;
    beat.misaligned         = mis;
  end

endmodule

// File: rtl/load_formatter.sv
// Pipelined MEM-stage load formatter: lane extraction feeding a registered
// output stage with a one-entry skid buffer. Optional macro: LOAD_UNALIGNED_EN.
module load_formatter
  import mem_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_MASK = 2,
  parameter int NB_OFS  = $clog2(NB_DATA/8)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_DATA-1:0] i_dato,
  input  logic [NB_OFS-1:0]  i_offset,
  input  logic [NB_MASK-1:0] i_mascara,
  input  logic               i_is_unsigned,
  input  logic [1:0]         i_merge_mode,
  input  logic [NB_DATA-1:0] i_rt_old,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_dato,
  output logic               o_misaligned
);

  // Handshake: a beat transfers on any rising edge where valid and ready are
  // both high; a producer holds valid and payload stable until that edge.

  load_beat_t         beat;
  logic [NB_DATA-1:0] new_dato;
  logic               accept;
  logic               out_free;
  logic               skid_valid;
  logic [NB_DATA-1:0] skid_dato;
  logic               skid_mis;

  load_lane_extract #(
    .NB_DATA (NB_DATA),
    .NB_MASK (NB_MASK),
    .NB_OFS  (NB_OFS)
  ) u_extract (
    .dato        (i_dato),
    .offset      (i_offset),
    .mascara     (i_mascara),
    .is_unsigned (i_is_unsigned),
    .merge_mode  (i_merge_mode),
    .rt_old      (i_rt_old),
    .beat        (beat)
  );

  assign new_dato = beat.dato[NB_DATA-1:0];
  assign accept   = i_valid && o_ready;
  assign out_free = !o_valid || i_ready;

  generate
    if (NB_DATA < MEM_NB_MAX) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^beat.dato[MEM_NB_MAX-1:NB_DATA];
    end
  endgenerate

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid      <= 1'b0;
      o_ready      <= 1'b1;
      o_dato       <= '0;
      o_misaligned <= 1'b0;
      skid_valid   <= 1'b0;
      skid_dato    <= '0;
      skid_mis     <= 1'b0;
    end else if (out_free) begin
      // o_ready is low whenever the skid is full, so the two branches never collide.
      if (skid_valid) begin
        o_valid      <= 1'b1;
        o_dato       <= skid_dato;
        o_misaligned <= skid_mis;
        skid_valid   <= 1'b0;
        o_ready      <= 1'b1;
      end else if (accept) begin
        o_valid      <= 1'b1;
        o_dato       <= new_dato;
        o_misaligned <= beat.misaligned;
      end else begin
        o_valid      <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_dato  <= new_dato;
      skid_mis   <= beat.misaligned;
      o_ready    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_load_formatter.sv
// Directed and randomized bench for load_formatter (32-bit datapath) using an
// expected-beat queue checked as beats leave the output port.
module tb_load_formatter;

  localparam int NB_DATA = 32;
  localparam int NB_MASK = 2;
  localparam int NB_OFS  = 2;

  logic               i_clock = 1'b0;
  logic               i_reset;
  logic               i_valid;
  logic               o_ready;
  logic [NB_DATA-1:0] i_dato;
  logic [NB_OFS-1:0]  i_offset;
  logic [NB_MASK-1:0] i_mascara;
  logic               i_is_unsigned;
  logic [1:0]         i_merge_mode;
  logic [NB_DATA-1:0] i_rt_old;
  logic               o_valid;
  logic               i_ready;
  logic [NB_DATA-1:0] o_dato;
  logic               o_misaligned;

  logic [NB_DATA:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  load_formatter #(
    .NB_DATA (NB_DATA),
    .NB_MASK (NB_MASK),
    .NB_OFS  (NB_OFS)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_dato        (i_dato),
    .i_offset      (i_offset),
    .i_mascara     (i_mascara),
    .i_is_unsigned (i_is_unsigned),
    .i_merge_mode  (i_merge_mode),
    .i_rt_old      (i_rt_old),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_dato        (o_dato),
    .o_misaligned  (o_misaligned)
  );

  // clock / reset
  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare each beat consumed downstream against the queue head
  always @(negedge i_clock) begin
    if (!i_reset && o_valid && i_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_beat: observed=%h expected=none", {o_misaligned, o_dato});
      end
      if (exp_q.size() != 0) chk("out_beat", {31'h0, o_misaligned, o_dato}, {31'h0, exp_q.pop_front()});
    end
  end

  // driver: present a beat, wait for acceptance, record expectation
  task automatic send(input logic [31:0] d, input logic [1:0] ofs, input logic [1:0] msk,
                      input logic uns, input logic [1:0] mode, input logic [31:0] rt,
                      input logic [32:0] exp);
    int   n = 0;
    logic rdy;
    i_dato        = d;
    i_offset      = ofs;
    i_mascara     = msk;
    i_is_unsigned = uns;
    i_merge_mode  = mode;
    i_rt_old      = rt;
    i_valid       = 1'b1;
    rdy = o_ready;
    while (!rdy && n < 50) begin
      @(posedge i_clock); #1;
      rdy = o_ready;
      n++;
    end
    checks++;
    assert (rdy) else begin
      errors++;
      $error("FAIL send_timeout: observed=o_ready low expected=o_ready high within 50 cycles");
    end
    if (rdy) begin
      exp_q.push_back(exp);
      @(posedge i_clock); #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || o_valid) && n < 100) begin
      @(posedge i_clock); #1;
      n++;
    end
    checks++;
    assert (exp_q.size() == 0 && !o_valid) else begin
      errors++;
      $error("FAIL drain: observed=%0d pending expected=0", exp_q.size());
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  ofs;
    logic [1:0]  msk;
    logic        uns;
    logic [7:0]  b;
    logic [15:0] h;
    logic [32:0] e;

    i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_dato = '0; i_offset = '0; i_mascara = '0; i_is_unsigned = 1'b0;
    i_merge_mode = 2'b00; i_rt_old = '0;
    repeat (2) @(posedge i_clock);
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_ready", o_ready, 1);
    chk("rst_o_dato", o_dato, 0);
    chk("rst_o_mis", o_misaligned, 0);
    i_reset = 1'b0;

    // byte lanes, including one-cycle latency
    send(32'h80FF_7F01, 2'd1, 2'b00, 1'b0, 2'b00, 32'h0, {1'b0, 32'h0000_007F});
    chk("lat_valid", o_valid, 1);
    chk("lat_dato", o_dato, 32'h0000_007F);
    send(32'h80FF_7F01, 2'd2, 2'b00, 1'b0, 2'b00, 32'h0, {1'b0, 32'hFFFF_FFFF});
    send(32'h80FF_7F01, 2'd2, 2'b00, 1'b1, 2'b00, 32'h0, {1'b0, 32'h0000_00FF});
    send(32'h80FF_7F01, 2'd3, 2'b00, 1'b0, 2'b00, 32'h0, {1'b0, 32'hFFFF_FF80});

    // half-words
    send(32'h8000_1234, 2'd2, 2'b01, 1'b0, 2'b00, 32'h0, {1'b0, 32'hFFFF_8000});
    send(32'h8000_1234, 2'd2, 2'b01, 1'b1, 2'b00, 32'h0, {1'b0, 32'h0000_8000});
    send(32'h8000_1234, 2'd0, 2'b01, 1'b0, 2'b00, 32'h0, {1'b0, 32'h0000_1234});

    // words, dword code on 32-bit, misalignment
    send(32'h8000_1234, 2'd2, 2'b11, 1'b0, 2'b00, 32'h0, {1'b1, 32'h0});
    send(32'h8000_1234, 2'd3, 2'b01, 1'b0, 2'b00, 32'h0, {1'b1, 32'h0});
    send(32'h8000_1234, 2'd0, 2'b11, 1'b0, 2'b00, 32'h0, {1'b0, 32'h8000_1234});
    send(32'h8000_1234, 2'd0, 2'b10, 1'b1, 2'b00, 32'h0, {1'b0, 32'h8000_1234});
    send(32'h8000_1234, 2'd1, 2'b10, 1'b0, 2'b00, 32'h0, {1'b1, 32'h0});

    // LWL / LWR merges
`ifdef LOAD_UNALIGNED_EN
    send(32'hAABB_CCDD, 2'd1, 2'b11, 1'b0, 2'b01, 32'h1122_3344, {1'b0, 32'hCCDD_3344});
    send(32'hAABB_CCDD, 2'd1, 2'b11, 1'b0, 2'b10, 32'h1122_3344, {1'b0, 32'h11AA_BBCC});
`else
    send(32'hAABB_CCDD, 2'd1, 2'b11, 1'b0, 2'b01, 32'h1122_3344, {1'b1, 32'h0});
    send(32'hAABB_CCDD, 2'd1, 2'b11, 1'b0, 2'b10, 32'h1122_3344, {1'b1, 32'h0});
`endif
    drain();

    // stall: A held, B in skid, C waits
    i_ready = 1'b0;
    send(32'h1122_3344, 2'd0, 2'b11, 1'b0, 2'b00, 32'h0, {1'b0, 32'h1122_3344});
    send(32'h5566_7788, 2'd3, 2'b00, 1'b1, 2'b00, 32'h0, {1'b0, 32'h0000_0055});
    chk("stall_o_ready", o_ready, 0);
    chk("stall_hold_valid", o_valid, 1);
    chk("stall_hold_dato", o_dato, 32'h1122_3344);
    @(posedge i_clock); #1;
    chk("stall2_o_ready", o_ready, 0);
    chk("stall2_hold_dato", o_dato, 32'h1122_3344);
    i_ready = 1'b1;
    send(32'hFFEE_0000, 2'd2, 2'b01, 1'b0, 2'b00, 32'h0, {1'b0, 32'hFFFF_FFEE});
    drain();
    chk("post_stall_o_ready", o_ready, 1);

    // reset with output and skid both full
    i_ready = 1'b0;
    send(32'hDEAD_BEEF, 2'd0, 2'b11, 1'b0, 2'b00, 32'h0, {1'b0, 32'hDEAD_BEEF});
    send(32'h0000_0080, 2'd0, 2'b00, 1'b0, 2'b00, 32'h0, {1'b0, 32'hFFFF_FF80});
    chk("full_o_ready", o_ready, 0);
    exp_q.delete();
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    chk("mid_rst_o_valid", o_valid, 0);
    chk("mid_rst_o_ready", o_ready, 1);
    chk("mid_rst_o_dato", o_dato, 0);
    chk("mid_rst_o_mis", o_misaligned, 0);
    i_reset = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clock); #1;
    chk("post_rst_no_beat", o_valid, 0);

    // random byte/half beats with random downstream backpressure
    for (int i = 0; i < 24; i++) begin
      d   = $urandom;
      ofs = 2'($urandom_range(0, 3));
      msk = 2'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      b   = 8'(d >> (8 * ofs));
      h   = 16'(d >> (16 * ofs[1]));
      if (msk == 2'b00)
        e = {1'b0, (uns ? 24'h0 : {24{b[7]}}), b};
      else if (ofs[0])
        e = {1'b1, 32'h0};
      else
        e = {1'b0, (uns ? 16'h0 : {16{h[15]}}), h};
      i_ready = o_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      send(d, ofs, msk, uns, 2'b00, $urandom, e);
    end
    i_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
